// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time RAM image loader.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package loader_pkg;

  // Frame start byte recognised while idle.
  localparam logic [7:0] MAGIC = 8'hA5;

  // Width of the running wrap-around checksum.
  localparam int CSUM_W = 8;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CSUM    = 3'd5
  } state_t;

endpackage

// File: rtl/loader_timer.sv
// Idle-gap watchdog: counts clocks since the last accepted byte while enabled.
// Latency: expired is combinational from the count; it asserts TIMEOUT_CYCLES-1 clocks after clr.
// Backpressure: none; clr/en are sampled every cycle.
//
// Ports:
//   clk, resetq  clock and asynchronous active-low reset
//   clr          restart the count (a byte was accepted)
//   en           count only while a frame is in progress; count is held at 0 otherwise
//   expired      high during the cycle in which the idle limit is reached
module loader_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetq,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // count holds the number of completed idle clocks; the limit is reached in the
  // cycle where count == TIMEOUT_CYCLES-1, so the owner reacts on the
  // TIMEOUT_CYCLES-th edge after the last byte. A zero limit never fires.
  always_comb begin
    expired = (TIMEOUT_CYCLES != 0) && en && (count == CW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Boot loader: frames UART bytes (A5, LEN16, LEN little-endian words, CSUM) into sequential RAM writes.
// Latency: write/status outputs are registered, one cycle after the accepted byte.
// Backpressure: none; every rx_valid strobe is consumed, including back-to-back strobes.
//
// Ports:
//   clk, resetq          clock and asynchronous active-low reset
//   rx_valid, rx_data    one-cycle received-byte strobe and byte
//   addr, wdata, we      RAM port B write (we is a one-cycle pulse)
//   busy                 frame in progress (holds the CPU in reset)
//   done, err            sticky result of the last frame; cleared by the next MAGIC
module ram_loader
  import loader_pkg::*;
#(
  parameter int LOG2ABITS      = 12,
  parameter int DWIDTH         = 16,      // only 16 is supported
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [LOG2ABITS-1:0] addr,
  output logic [DWIDTH-1:0]    wdata,
  output logic                 we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // One extra index bit so a full-depth image (LEN == depth) terminates cleanly.
  localparam int          IW    = LOG2ABITS + 1;
  localparam logic [16:0] DEPTH = 17'(1) << LOG2ABITS;

  state_t            state;
  logic [15:0]       len;
  logic [IW-1:0]     idx;
  logic [7:0]        lo_byte;
  logic [CSUM_W-1:0] sum;

  logic              tmo;
  logic [15:0]       len_full;
  logic [IW-1:0]     idx_nxt;
  logic [CSUM_W-1:0] sum_nxt;

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetq (resetq),
    .clr    (rx_valid),
    .en     (busy),
    .expired(tmo)
  );

  always_comb begin
    len_full = {rx_data, len[7:0]};
    idx_nxt  = idx + IW'(1);
    sum_nxt  = sum + CSUM_W'(rx_data);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state   <= ST_IDLE;
      len     <= '0;
      idx     <= '0;
      lo_byte <= '0;
      sum     <= '0;
      addr    <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      we <= 1'b0;
      // The watchdog wins over a byte arriving in the same cycle; that byte is dropped.
      if (busy && tmo) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == MAGIC) begin
              state <= ST_LEN_LO;
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
              sum   <= '0;
              idx   <= '0;
            end
          end
          ST_LEN_LO: begin
            len[7:0] <= rx_data;
            sum      <= sum_nxt;
            state    <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len[15:8] <= rx_data;
            sum       <= sum_nxt;
            if ({1'b0, len_full} > DEPTH) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            lo_byte <= rx_data;
            sum     <= sum_nxt;
            state   <= ST_DATA_HI;
          end
          ST_DATA_HI: begin
            addr  <= idx[LOG2ABITS-1:0];
            wdata <= DWIDTH'({rx_data, lo_byte});
            we    <= 1'b1;
            idx   <= idx_nxt;
            sum   <= sum_nxt;
            state <= (16'(idx_nxt) == len) ? ST_CSUM : ST_DATA_LO;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (rx_data == sum) done <= 1'b1;
            else                err  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus pushes expected writes/status, a monitor pops and compares.
// Latency: outputs sampled on the falling edge, half a cycle after the registering edge.
// Backpressure: none; the driver may strobe bytes back-to-back.
module tb_ram_loader;

  localparam int AW    = 12;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetq = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic          we;
  logic          busy;
  logic          done;
  logic          err;

  ram_loader #(
    .LOG2ABITS     (AW),
    .DWIDTH        (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_write;
    logic [AW-1:0] a;
    logic [15:0]   d;
    bit            ok;
    bit            bad;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] good_csum(int len, logic [15:0] w[$]);
    int s;
    s = (len & 255) + ((len >> 8) & 255);
    foreach (w[i]) s += (w[i] & 255) + ((w[i] >> 8) & 255);
    return 8'(s % 256);
  endfunction

  task automatic expect_frame(int len, logic [15:0] w[$], logic [7:0] csum);
    exp_t e;
    if (len > DEPTH) begin
      e = '{is_write: 0, a: '0, d: '0, ok: 0, bad: 1};
      expq.push_back(e);
      return;
    end
    for (int i = 0; i < len; i++) begin
      e = '{is_write: 1, a: AW'(i), d: w[i], ok: 0, bad: 0};
      expq.push_back(e);
    end
    e.is_write = 0;
    e.ok  = (csum == good_csum(len, w));
    e.bad = !e.ok;
    expq.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic put(logic [7:0] b, int max_gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic send_frame(int len, logic [15:0] w[$], logic [7:0] csum, int max_gap);
    expect_frame(len, w, csum);
    put(8'hA5, max_gap);
    put(8'(len & 255), max_gap);
    put(8'((len >> 8) & 255), max_gap);
    if (len <= DEPTH) begin
      for (int i = 0; i < len; i++) begin
        put(w[i][7:0], max_gap);
        put(w[i][15:8], max_gap);
      end
      put(csum, max_gap);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit   prev_busy;
    exp_t e;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (!resetq) begin
        prev_busy = 0;
      end else begin
        if (we) begin
          if (expq.size() == 0 || !expq[0].is_write) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected none", addr, wdata);
          end else begin
            e = expq.pop_front();
            check("write_addr", 32'(addr), 32'(e.a));
            check("write_data", 32'(wdata), 32'(e.d));
          end
        end
        if (prev_busy && !busy) begin
          if (expq.size() == 0 || expq[0].is_write) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_status: got done %0b err %0b, expected a pending write or nothing", done, err);
          end else begin
            e = expq.pop_front();
            check("status_done", 32'(done), 32'(e.ok));
            check("status_err",  32'(err),  32'(e.bad));
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [15:0] w[$];
    logic [15:0] none[$];
    int          len;
    int          wait_cnt;
    logic [7:0]  g;
    logic [7:0]  cs;

    #12;
    check("rst_addr",  32'(addr),  0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_we",    32'(we),    0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    check("rst_err",   32'(err),   0);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);

    // Nominal, back-to-back bytes
    w = '{16'h1234, 16'h5678, 16'h9ABC};
    send_frame(3, w, good_csum(3, w), 0);
    // Bad checksum
    send_frame(3, w, 8'h53, 2);
    // Zero length
    send_frame(0, none, good_csum(0, none), 1);
    // A5 as data
    w = '{16'hA5A5};
    send_frame(1, w, good_csum(1, w), 1);

    // Oversize: err and busy low the cycle after LEN_HI
    expect_frame(16'h1001, none, 8'h00);
    put(8'hA5, 0);
    put(8'h01, 0);
    put(8'h10, 0);
    check("oversize_err",  32'(err),  1);
    check("oversize_busy", 32'(busy), 0);
    check("oversize_no_we", 32'(we), 0);
    repeat (2) @(negedge clk);

    // Leading garbage then a valid frame
    put(8'h00, 1); put(8'hFF, 1); put(8'h5A, 1);
    w = '{16'hBEEF, 16'h0102};
    send_frame(2, w, good_csum(2, w), 1);

    // Timeout: stall after first data byte
    expq.push_back('{is_write: 0, a: '0, d: '0, ok: 0, bad: 1});
    put(8'hA5, 0); put(8'h03, 0); put(8'h00, 0); put(8'h34, 0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_busy_before", 32'(busy), 1);
    check("tmo_err_before",  32'(err),  0);
    @(negedge clk);
    check("tmo_err_at",  32'(err),  1);
    check("tmo_busy_at", 32'(busy), 0);
    repeat (2) @(negedge clk);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        put(g, 2);
      end
      len = $urandom_range(0, 6);
      w.delete();
      for (int i = 0; i < len; i++)
        w.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
      cs = good_csum(len, w);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      send_frame(len, w, cs, 3);
    end

    // Maximum length, last write at top address
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom));
    send_frame(DEPTH, w, good_csum(DEPTH, w), 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-frame
    put(8'hA5, 1); put(8'h02, 1); put(8'h00, 1); put(8'h11, 0);
    #2;
    resetq = 1'b0;
    #1;
    check("arst_busy",  32'(busy),  0);
    check("arst_addr",  32'(addr),  0);
    check("arst_wdata", 32'(wdata), 0);
    check("arst_done",  32'(done),  0);
    check("arst_err",   32'(err),   0);
    check("arst_we",    32'(we),    0);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);

    // Loader recovers after reset
    w = '{16'hCAFE};
    send_frame(1, w, good_csum(1, w), 1);

    wait_cnt = 0;
    while (expq.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("queue_drained", 32'(expq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
